vga_vtiming_gen: RTL
====================

// Module: vga_vtiming_gen
// PURPOSE
//  Vertical timing stage of the VGA pipeline; sits directly downstream of the horizontal counter.
//  Counts lines on the horizontal counter's end-of-line pulse and produces vsync, row and vblank.
//  Gates the horizontal rgb enable into a frame-wide video_on for the pixel generator.
//  Default timing is 640x480@60 (525 lines/frame).
// PARAMETERS
//  V_ACTIVE  480  visible lines
//  V_FP      10   front-porch lines
//  V_SYNC    2    sync-pulse lines
//  V_BP      33   back-porch lines
//  VS_POL    0    vsync active level (0 = active-low)
//  ROW_W     10   row counter width; must hold V_ACTIVE+V_FP+V_SYNC+V_BP-1
// PORTS
//  clk          in   1      pixel clock, same domain as the horizontal counter
//  rst          in   1      reset: synchronous, active-high
//  line_end     in   1      1-cycle pulse on the horizontal counter's final column
//  hs_rgb_en    in   1      horizontal active-video enable
//  vsync        out  1      vertical sync, registered
//  row          out  ROW_W  current line, 0..V_TOTAL-1, registered
//  vblank       out  1      1 outside the visible lines, registered
//  video_on     out  1      hs_rgb_en & ~vblank, combinational
//  frame_start  out  1      1-cycle pulse when row wraps to 0
//  frame_cnt    out  8      frame counter; see CONFIGURATION
// BEHAVIOUR
//  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. All arithmetic is unsigned ROW_W bits.
//  - Reset values: row=0, state=V_ACT, vsync=~VS_POL, vblank=0, frame_start=0, frame_cnt=0.
//  - rst overrides line_end in the same cycle.
//  - FSM states: V_ACT -> V_FP -> V_SYN -> V_BP -> V_ACT. Transitions occur only on line_end.
//    - V_ACT  -> V_FP  when row == V_ACTIVE-1
//    - V_FP   -> V_SYN when row == V_ACTIVE+V_FP-1
//    - V_SYN  -> V_BP  when row == V_ACTIVE+V_FP+V_SYNC-1
//    - V_BP   -> V_ACT when row == V_TOTAL-1
//  - On line_end: row <= (row == V_TOTAL-1) ? 0 : row+1. Without line_end, row and state hold.
//  - Latency: row, state, vsync and vblank update on the clock edge that samples line_end.
//    The first column of the new line therefore sees the new values.
//  - vsync = VS_POL in V_SYN, otherwise ~VS_POL. vblank = (state != V_ACT). Both registered from next-state.
//  - frame_start is 1 for exactly one cycle: the cycle after the line_end that wraps row to 0.
//    It is 0 otherwise, including immediately after reset.
//  - video_on has zero latency relative to hs_rgb_en; it is forced 0 while rst=1.
//  - Illegal state/row combination (row >= V_TOTAL or an undefined state) recovers to row=0, V_ACT
//    on the next cycle; frame_start stays 0.
//  - Reset mid-frame: next cycle holds reset values; counting resumes on the next line_end.
//  - line_end asserted on consecutive cycles is counted each cycle. No filtering.
// CONFIGURATION
//  - VGA_FRAME_CNT_EN defined: frame_cnt increments, wrapping 255 -> 0, in the same cycle
//    frame_start asserts. Used for animation/blink timing.
//  - VGA_FRAME_CNT_EN undefined: frame_cnt is tied to 8'd0 and no counter register is built.
//    The port remains present.
// STRUCTURE
//  - Shared package vga_timing_pkg holds:
//    - typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} vstate_t
//    - default 640x480 constants for the H and V timings, shared with the horizontal counter
//  - No sub-module: one always_ff for row/state/flags plus one always_comb for next-state
//    and video_on.
// TESTING
//  1. rst=1 for 3 cycles, line_end toggling -> row=0, vsync=1, vblank=0, frame_start=0, video_on=0.
//  2. 480 line_end pulses (800 clk apart), hs_rgb_en=1 -> row=480, vblank=1, video_on=0, vsync=1.
//  3. Continue to the 490th pulse -> vsync=0 for rows 490-491 only; vsync=1 at row 492.
//  4. 525th pulse -> row=0, vblank=0, frame_start=1 for exactly one cycle; frame_cnt=1 with macro, 0 without.
//  5. At row=300, pulse rst for 1 cycle together with line_end -> row=0, V_ACT next cycle;
//     the next line_end gives row=1.
//  6. VGA_FRAME_CNT_EN, run 256 frames -> frame_cnt sequences 1..255 then 0; no line_end gaps -> row stable.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: vertical FSM states and default 640x480@60 H/V timing.
package vga_timing_pkg;

    typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} vstate_t;

    // Horizontal defaults, shared with the horizontal counter
    localparam int unsigned H_ACTIVE_PIX  = 640;
    localparam int unsigned H_FP_PIX      = 16;
    localparam int unsigned H_SYNC_PIX    = 96;
    localparam int unsigned H_BP_PIX      = 48;
    localparam int unsigned H_TOTAL_PIX   = H_ACTIVE_PIX + H_FP_PIX + H_SYNC_PIX + H_BP_PIX;
    localparam int unsigned COL_W_DEF     = 10;

    // Vertical defaults
    localparam int unsigned V_ACTIVE_LINES = 480;
    localparam int unsigned V_FP_LINES     = 10;
    localparam int unsigned V_SYNC_LINES   = 2;
    localparam int unsigned V_BP_LINES     = 33;
    localparam int unsigned V_TOTAL_LINES  = V_ACTIVE_LINES + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;
    localparam int unsigned ROW_W_DEF      = 10;

endpackage

// File: rtl/vga_vtiming_gen.sv
// Vertical VGA timing: counts lines on line_end, drives vsync/row/vblank/frame_start and video_on.
// Optional frame counter built only when VGA_FRAME_CNT_EN is defined; otherwise frame_cnt is 0.
module vga_vtiming_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned V_ACTIVE = V_ACTIVE_LINES,
    parameter int unsigned V_FP     = V_FP_LINES,
    parameter int unsigned V_SYNC   = V_SYNC_LINES,
    parameter int unsigned V_BP     = V_BP_LINES,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned ROW_W    = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_end,
    input  logic             hs_rgb_en,
    output logic             vsync,
    output logic [ROW_W-1:0] row,
    output logic             vblank,
    output logic             video_on,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [ROW_W-1:0] ROW_ACT_END = ROW_W'(V_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_FP_END  = ROW_W'(V_ACTIVE + V_FP - 1);
    localparam logic [ROW_W-1:0] ROW_SYN_END = ROW_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(V_TOTAL - 1);

    vstate_t          state;
    vstate_t          state_nxt;
    logic [ROW_W-1:0] row_nxt;
    logic             frame_start_nxt;

    // Next-state, row advance and zero-latency video gate
    always_comb begin
        state_nxt       = state;
        row_nxt         = row;
        frame_start_nxt = 1'b0;
        video_on        = hs_rgb_en & ~vblank & ~rst;

        if (row > ROW_LAST) begin
            state_nxt = vga_timing_pkg::V_ACT;
            row_nxt   = '0;
        end else if (line_end) begin
            row_nxt         = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            frame_start_nxt = (row == ROW_LAST);
            case (state)
                vga_timing_pkg::V_ACT: if (row == ROW_ACT_END) state_nxt = vga_timing_pkg::V_FP;
                vga_timing_pkg::V_FP:  if (row == ROW_FP_END)  state_nxt = vga_timing_pkg::V_SYN;
                vga_timing_pkg::V_SYN: if (row == ROW_SYN_END) state_nxt = vga_timing_pkg::V_BP;
                vga_timing_pkg::V_BP:  if (row == ROW_LAST)    state_nxt = vga_timing_pkg::V_ACT;
                default: begin
                    state_nxt       = vga_timing_pkg::V_ACT;
                    row_nxt         = '0;
                    frame_start_nxt = 1'b0;
                end
            endcase
        end
    end

    // Flags are registered from next-state so they line up with the new row
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= vga_timing_pkg::V_ACT;
            row         <= '0;
            vsync       <= ~VS_POL;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            row         <= row_nxt;
            vsync       <= (state_nxt == vga_timing_pkg::V_SYN) ? VS_POL : ~VS_POL;
            vblank      <= (state_nxt != vga_timing_pkg::V_ACT);
            frame_start <= frame_start_nxt;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (frame_start_nxt) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
